// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/scoreboard unit: result_src values, forwarding selects, widths.
// Constants only; no timing or flow-control behaviour of its own.
package hazard_pkg;

    localparam int REG_AW    = 5;
    localparam int RES_SRC_W = 3;

    localparam logic [RES_SRC_W-1:0] RES_ALU  = 3'b000;
    localparam logic [RES_SRC_W-1:0] RES_LOAD = 3'b001;
    localparam logic [RES_SRC_W-1:0] RES_PC4  = 3'b010;
    localparam logic [RES_SRC_W-1:0] RES_LU   = 3'b100;
    localparam logic [RES_SRC_W-1:0] LOAD_SRC = RES_LOAD;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10,
        FWD_LU  = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for long-latency ops; RAW/WAW/full terms are combinational, state updates next edge.
// Blocks new issues when the pipe stalls or MAX_OUTSTANDING ops are in flight without a completion.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS        = 32,
    parameter int REG_AW          = hazard_pkg::REG_AW,
    parameter int MAX_OUTSTANDING = 4,
    parameter bit ZERO_HARDWIRED  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs3_d,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              reg_write_e,
    input  logic              lu_issue_e,
    input  logic              lu_done,
    input  logic [REG_AW-1:0] lu_done_rd,
    input  logic              pipe_stall,
    output logic              sb_raw,
    output logic              sb_waw,
    output logic              sb_full,
    output logic              lu_busy,
    output logic              sb_err
);

    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                done_ok;
    logic                issue_ok;

    function automatic logic is_live(input logic [REG_AW-1:0] r);
        return !(ZERO_HARDWIRED && (r == '0));
    endfunction

    // A source being completed this cycle is not a hazard: it is bypassed on the LU forward path.
    function automatic logic raw_hit(input logic [REG_AW-1:0]   rs,
                                     input logic [NUM_REGS-1:0] bv,
                                     input logic                done,
                                     input logic [REG_AW-1:0]   done_rd);
        return is_live(rs) && bv[rs] && !(done && (done_rd == rs));
    endfunction

    always_comb begin
        sb_raw   = raw_hit(rs1_d, busy, lu_done, lu_done_rd)
                || raw_hit(rs2_d, busy, lu_done, lu_done_rd)
                || raw_hit(rs3_d, busy, lu_done, lu_done_rd);
        sb_waw   = reg_write_e && busy[rd_e];
        sb_full  = lu_issue_e && (cnt == CNT_MAX) && !lu_done;
        done_ok  = lu_done && busy[lu_done_rd] && (cnt != '0);
        issue_ok = lu_issue_e && !(pipe_stall || sb_raw || sb_waw || sb_full);

        // Clear before set so a same-register issue wins over the completion.
        busy_nxt = busy;
        if (done_ok) begin
            busy_nxt[lu_done_rd] = 1'b0;
        end
        if (issue_ok && is_live(rd_e)) begin
            busy_nxt[rd_e] = 1'b1;
        end

        cnt_nxt = cnt;
        if (issue_ok && !done_ok) begin
            if (cnt != CNT_MAX) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (!issue_ok && done_ok) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= '0;
            cnt    <= '0;
            sb_err <= 1'b0;
        end else begin
            busy <= busy_nxt;
            cnt  <= cnt_nxt;
            if (lu_done && !done_ok) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign lu_busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit: forwarding selects, load-use/branch/scoreboard stalls; all outputs combinational, state next edge.
// Any hazard stalls F and D and flushes E for as long as the condition holds.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int                   NUM_REGS        = 32,
    parameter int                   REG_AW          = hazard_pkg::REG_AW,
    parameter int                   RES_SRC_W       = hazard_pkg::RES_SRC_W,
    parameter logic [RES_SRC_W-1:0] LOAD_SRC        = RES_SRC_W'(hazard_pkg::LOAD_SRC),
    parameter int                   MAX_OUTSTANDING = 4,
    parameter bit                   ZERO_HARDWIRED  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_AW-1:0]    rs1_d,
    input  logic [REG_AW-1:0]    rs2_d,
    input  logic [REG_AW-1:0]    rs3_d,
    input  logic [REG_AW-1:0]    rs1_e,
    input  logic [REG_AW-1:0]    rs2_e,
    input  logic [REG_AW-1:0]    rd_e,
    input  logic [REG_AW-1:0]    rd_m,
    input  logic [REG_AW-1:0]    rd_w,
    input  logic                 reg_write_e,
    input  logic                 reg_write_m,
    input  logic                 reg_write_w,
    input  logic [RES_SRC_W-1:0] result_src_e,
    input  logic [RES_SRC_W-1:0] result_src_m,
    input  logic                 branch_d,
    input  logic                 lu_issue_e,
    input  logic                 lu_done,
    input  logic [REG_AW-1:0]    lu_done_rd,
    output logic [1:0]           forward_a,
    output logic [1:0]           forward_b,
    output logic                 forward_ad,
    output logic                 forward_bd,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_e,
    output logic                 lu_busy,
    output logic                 sb_err
);

    logic load_use;
    logic branch_stall;
    logic sb_raw;
    logic sb_waw;
    logic sb_full;
    logic stall;

    function automatic logic is_live(input logic [REG_AW-1:0] r);
        return !(ZERO_HARDWIRED && (r == '0));
    endfunction

    // M beats the LU completion, which beats W: youngest producer first.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = FWD_REG;
        if (reg_write_m && (rd_m == rs) && is_live(rs)) begin
            sel = FWD_M;
        end else if (lu_done && (lu_done_rd == rs) && is_live(rs)) begin
            sel = FWD_LU;
        end else if (reg_write_w && (rd_w == rs) && is_live(rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    always_comb begin
        forward_a  = fwd_sel(rs1_e);
        forward_b  = fwd_sel(rs2_e);
        forward_ad = reg_write_m && (rd_m == rs1_d) && is_live(rs1_d);
        forward_bd = reg_write_m && (rd_m == rs2_d) && is_live(rs2_d);

        load_use = (result_src_e == LOAD_SRC) && reg_write_e && is_live(rd_e)
                && ((rd_e == rs1_d) || (rd_e == rs2_d) || (rd_e == rs3_d));

        branch_stall = branch_d
                && ((reg_write_e && is_live(rd_e) && ((rd_e == rs1_d) || (rd_e == rs2_d)))
                 || ((result_src_m == LOAD_SRC) && is_live(rd_m)
                     && ((rd_m == rs1_d) || (rd_m == rs2_d))));
    end

    hazard_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .REG_AW          (REG_AW),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .ZERO_HARDWIRED  (ZERO_HARDWIRED)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs3_d       (rs3_d),
        .rd_e        (rd_e),
        .reg_write_e (reg_write_e),
        .lu_issue_e  (lu_issue_e),
        .lu_done     (lu_done),
        .lu_done_rd  (lu_done_rd),
        .pipe_stall  (load_use | branch_stall),
        .sb_raw      (sb_raw),
        .sb_waw      (sb_waw),
        .sb_full     (sb_full),
        .lu_busy     (lu_busy),
        .sb_err      (sb_err)
    );

    assign stall   = load_use | branch_stall | sb_raw | sb_waw | sb_full;
    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: an integer instance (x0 hardwired, 4 outstanding) and an FP
// instance (f0 ordinary, 2 outstanding) share stimulus and are checked against a reference model.
module tb_hazard_scoreboard_unit;

    localparam logic [2:0] LD = 3'b001;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_d, rs2_d, rs3_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, lu_done_rd;
    logic       reg_write_e, reg_write_m, reg_write_w, branch_d, lu_issue_e, lu_done;
    logic [2:0] result_src_e, result_src_m;

    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic       fad [2];
    logic       fbd [2];
    logic       sf [2];
    logic       sd [2];
    logic       fe [2];
    logic       lb [2];
    logic       er [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: per instance, which registers are owned by an in-flight op, op count, error flag.
    bit busy_m [2][32];
    int cnt_m  [2];
    bit err_m  [2];

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.MAX_OUTSTANDING(4), .ZERO_HARDWIRED(1'b1)) u_int (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs3_d(rs3_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .result_src_e(result_src_e), .result_src_m(result_src_m), .branch_d(branch_d),
        .lu_issue_e(lu_issue_e), .lu_done(lu_done), .lu_done_rd(lu_done_rd),
        .forward_a(fa[0]), .forward_b(fb[0]), .forward_ad(fad[0]), .forward_bd(fbd[0]),
        .stall_f(sf[0]), .stall_d(sd[0]), .flush_e(fe[0]), .lu_busy(lb[0]), .sb_err(er[0])
    );

    hazard_scoreboard_unit #(.MAX_OUTSTANDING(2), .ZERO_HARDWIRED(1'b0)) u_fp (
        .clk(clk), .reset(reset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs3_d(rs3_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .result_src_e(result_src_e), .result_src_m(result_src_m), .branch_d(branch_d),
        .lu_issue_e(lu_issue_e), .lu_done(lu_done), .lu_done_rd(lu_done_rd),
        .forward_a(fa[1]), .forward_b(fb[1]), .forward_ad(fad[1]), .forward_bd(fbd[1]),
        .stall_f(sf[1]), .stall_d(sd[1]), .flush_e(fe[1]), .lu_busy(lb[1]), .sb_err(er[1])
    );

    function automatic bit live(input int k, input int r);
        return !(k == 0 && r == 0);
    endfunction

    function automatic int max_out(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic logic [1:0] m_fwd(input int k, input int rs);
        if (reg_write_m && int'(rd_m) == rs && live(k, rs)) return 2'd2;
        if (lu_done && int'(lu_done_rd) == rs && live(k, rs)) return 2'd3;
        if (reg_write_w && int'(rd_w) == rs && live(k, rs)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit m_stall(input int k);
        int  src [3];
        bit  lu_h, br_h, raw_h, waw_h, full_h;
        int  re, rm;
        src[0] = int'(rs1_d);
        src[1] = int'(rs2_d);
        src[2] = int'(rs3_d);
        re = int'(rd_e);
        rm = int'(rd_m);
        lu_h = (result_src_e == LD) && reg_write_e && live(k, re)
             && (re == src[0] || re == src[1] || re == src[2]);
        br_h = branch_d && ((reg_write_e && live(k, re) && (re == src[0] || re == src[1]))
             || ((result_src_m == LD) && live(k, rm) && (rm == src[0] || rm == src[1])));
        raw_h = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (live(k, src[i]) && busy_m[k][src[i]] && !(lu_done && int'(lu_done_rd) == src[i]))
                raw_h = 1'b1;
        end
        waw_h  = reg_write_e && busy_m[k][re];
        full_h = lu_issue_e && (cnt_m[k] == max_out(k)) && !lu_done;
        return lu_h | br_h | raw_h | waw_h | full_h;
    endfunction

    function automatic logic [10:0] m_out(input int k);
        bit s, ad, bd;
        s  = m_stall(k);
        ad = reg_write_m && rd_m == rs1_d && live(k, int'(rs1_d));
        bd = reg_write_m && rd_m == rs2_d && live(k, int'(rs2_d));
        return {m_fwd(k, int'(rs1_e)), m_fwd(k, int'(rs2_e)), ad, bd, s, s, s,
                cnt_m[k] != 0, err_m[k]};
    endfunction

    function automatic logic [10:0] obs_vec(input int k);
        return {fa[k], fb[k], fad[k], fbd[k], sf[k], sd[k], fe[k], lb[k], er[k]};
    endfunction

    task automatic m_update();
        for (int k = 0; k < 2; k++) begin
            bit s, acc, dok;
            if (reset) begin
                for (int r = 0; r < 32; r++) busy_m[k][r] = 1'b0;
                cnt_m[k] = 0;
                err_m[k] = 1'b0;
            end else begin
                s   = m_stall(k);
                acc = lu_issue_e && !s;
                dok = lu_done && busy_m[k][lu_done_rd] && cnt_m[k] > 0;
                if (lu_done && !dok) err_m[k] = 1'b1;
                if (dok) busy_m[k][lu_done_rd] = 1'b0;
                if (acc && live(k, int'(rd_e))) busy_m[k][rd_e] = 1'b1;
                cnt_m[k] = cnt_m[k] + int'(acc) - int'(dok);
                if (cnt_m[k] < 0) cnt_m[k] = 0;
                if (cnt_m[k] > max_out(k)) cnt_m[k] = max_out(k);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic eval_cyc(input string tag);
        @(negedge clk);
        chk({tag, "/int"}, obs_vec(0), m_out(0));
        chk({tag, "/fp"},  obs_vec(1), m_out(1));
    endtask

    task automatic adv();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic cyc(input string tag);
        eval_cyc(tag);
        adv();
    endtask

    task automatic idle();
        {rs1_d, rs2_d, rs3_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, lu_done_rd} = '0;
        {reg_write_e, reg_write_m, reg_write_w, branch_d, lu_issue_e, lu_done} = '0;
        result_src_e = 3'b000;
        result_src_m = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        adv();
        cyc("rst");
        reset = 1'b0;
        eval_cyc("idle");
        chk("reset_outs_int", obs_vec(0), 11'd0);
        chk("reset_outs_fp", obs_vec(1), 11'd0);
        adv();

        // Load to x5 in E, consumer in D: one stall, then W forward.
        rd_e = 5; reg_write_e = 1; result_src_e = LD; rs1_d = 5;
        eval_cyc("lu_a");
        chk("load_use_stall", 11'(sf[0]), 11'd1);
        chk("load_use_flush_fp", 11'(fe[1]), 11'd1);
        adv();
        reg_write_e = 0; result_src_e = 3'b000; rd_e = 0;
        reg_write_m = 1; rd_m = 5; result_src_m = LD;
        eval_cyc("lu_b");
        chk("load_use_released", 11'(sd[0]), 11'd0);
        adv();
        rs1_d = 0; rs1_e = 5; reg_write_m = 0; rd_m = 0; result_src_m = 3'b000;
        reg_write_w = 1; rd_w = 5;
        eval_cyc("lu_c");
        chk("load_use_fwd_w", 11'(fa[0]), 11'd1);
        adv();

        // Long-latency op to x7; decode reader waits until completion.
        idle();
        lu_issue_e = 1; rd_e = 7; reg_write_e = 1;
        cyc("ll_issue");
        idle();
        rs1_d = 7;
        for (int i = 0; i < 3; i++) begin
            eval_cyc("ll_wait");
            chk("ll_raw_stall_int", 11'(sf[0]), 11'd1);
            chk("ll_raw_stall_fp", 11'(sf[1]), 11'd1);
            adv();
        end
        lu_done = 1; lu_done_rd = 7; rs1_e = 7;
        eval_cyc("ll_done");
        chk("ll_done_no_stall", 11'(sf[0]), 11'd0);
        chk("ll_done_fwd_lu", 11'(fa[0]), 11'd3);
        adv();
        idle();
        eval_cyc("ll_after");
        chk("ll_drained", 11'(lb[0]), 11'd0);
        chk("ll_no_err", 11'(er[0]), 11'd0);
        adv();

        // Destination register 0: never busy on the integer file, ordinary on the FP file.
        lu_issue_e = 1; rd_e = 0;
        cyc("z_issue");
        idle();
        eval_cyc("z_read");
        chk("zero_no_stall_int", 11'(sf[0]), 11'd0);
        chk("zero_stall_fp", 11'(sf[1]), 11'd1);
        chk("zero_cnt_int", 11'(lb[0]), 11'd1);
        adv();
        reset = 1'b1;
        cyc("z_rst");
        reset = 1'b0;

        // Outstanding limit: FP instance saturates at 2.
        lu_issue_e = 1; rd_e = 1;
        cyc("full_1");
        rd_e = 2;
        cyc("full_2");
        rd_e = 3;
        eval_cyc("full_3");
        chk("full_stall_fp", 11'(sf[1]), 11'd1);
        chk("full_nostall_int", 11'(sf[0]), 11'd0);
        adv();
        rd_e = 4; lu_done = 1; lu_done_rd = 1;
        eval_cyc("full_swap");
        chk("full_swap_fp", 11'(sf[1]), 11'd0);
        adv();
        lu_done = 0; rd_e = 5;
        eval_cyc("full_again");
        chk("full_still_fp", 11'(sf[1]), 11'd1);
        adv();
        idle();
        reset = 1'b1;
        cyc("full_rst");
        reset = 1'b0;

        // Forward priority and branch-operand hazards.
        rs1_e = 3; rd_m = 3; rd_w = 3; reg_write_m = 1; reg_write_w = 1;
        eval_cyc("fwd_prio");
        chk("fwd_m_over_w_int", 11'(fa[0]), 11'd2);
        chk("fwd_m_over_w_fp", 11'(fa[1]), 11'd2);
        adv();
        branch_d = 1; rs1_d = 3; reg_write_e = 1; rd_e = 3;
        eval_cyc("br_e");
        chk("branch_stall", 11'(sf[0]), 11'd1);
        adv();
        rd_e = 0;
        eval_cyc("br_zero");
        chk("branch_zero_int", 11'(sf[0]), 11'd0);
        chk("branch_zero_fp", 11'(sf[1]), 11'd1);
        adv();
        idle();

        // Reset aborts two in-flight ops; a late completion is an error that sticks.
        lu_issue_e = 1; rd_e = 4;
        cyc("ab_1");
        rd_e = 6;
        cyc("ab_2");
        idle();
        reset = 1'b1;
        cyc("ab_rst");
        reset = 1'b0;
        lu_done = 1; lu_done_rd = 4;
        cyc("ab_done");
        idle();
        for (int i = 0; i < 3; i++) begin
            eval_cyc("ab_hold");
            chk("err_sticky_int", 11'(er[0]), 11'd1);
            chk("err_sticky_fp", 11'(er[1]), 11'd1);
            chk("err_cnt_zero", 11'(lb[0]), 11'd0);
            adv();
        end
        reset = 1'b1;
        cyc("ab_rst2");
        reset = 1'b0;
        eval_cyc("ab_clear");
        chk("err_cleared", 11'(er[0]), 11'd0);
        adv();

        // Randomised traffic over a small register window so hazards collide often.
        for (int n = 0; n < 800; n++) begin
            reset        = ($urandom_range(0, 49) == 0);
            rs1_d        = 5'($urandom_range(0, 7));
            rs2_d        = 5'($urandom_range(0, 7));
            rs3_d        = 5'($urandom_range(0, 7));
            rs1_e        = 5'($urandom_range(0, 7));
            rs2_e        = 5'($urandom_range(0, 7));
            rd_e         = 5'($urandom_range(0, 7));
            rd_m         = 5'($urandom_range(0, 7));
            rd_w         = 5'($urandom_range(0, 7));
            lu_done_rd   = 5'($urandom_range(0, 7));
            reg_write_e  = 1'($urandom_range(0, 1));
            reg_write_m  = 1'($urandom_range(0, 1));
            reg_write_w  = 1'($urandom_range(0, 1));
            branch_d     = ($urandom_range(0, 3) == 0);
            lu_issue_e   = ($urandom_range(0, 2) == 0);
            lu_done      = ($urandom_range(0, 3) == 0);
            result_src_e = ($urandom_range(0, 2) == 0) ? LD : 3'($urandom_range(0, 7));
            result_src_m = ($urandom_range(0, 2) == 0) ? LD : 3'($urandom_range(0, 7));
            cyc("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
